vga_scaled_addresser: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/replicate_counter.sv | 45 ++++
 rtl/vga_scaled_addresser.sv | 102 ++++++++++
 tb/tb_vga_scaled_addresser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480 timing constants, scale encodings and the scale decode helper
// shared by the framebuffer addresser.
package vga_pkg;

    localparam int HPIXELS = 800;
    localparam int VLINES  = 521;
    localparam int HBP     = 144;
    localparam int HFP     = 784;
    localparam int VBP     = 31;
    localparam int VFP     = 511;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    // Returns S-1 for the replication factor S; the reserved code falls back to 1x.
    function automatic logic [1:0] scale_m1(input logic [1:0] sel);
        case (sel)
            SCALE_2X: return 2'd1;
            SCALE_4X: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/replicate_counter.sv
// Index plus replication sub-count: the index steps by STEP once every S advances.
// The idx output already reflects a same-cycle clear so the caller can use it directly.
module replicate_counter #(
    parameter int W    = 16,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic         advance,
    input  logic [1:0]   s_m1,
    output logic [W-1:0] idx
);

    logic [W-1:0] idx_q;
    logic [1:0]   sub_q;
    logic [1:0]   sub_cur;

    always_comb begin
        idx     = clear ? '0 : idx_q;
        sub_cur = clear ? 2'd0 : sub_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            sub_q <= 2'd0;
        end else if (en) begin
            if (advance) begin
                if (sub_cur == s_m1) begin
                    sub_q <= 2'd0;
                    idx_q <= idx + W'(STEP);
                end else begin
                    sub_q <= sub_cur + 2'd1;
                    idx_q <= idx;
                end
            end else if (clear) begin
                idx_q <= '0;
                sub_q <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/vga_scaled_addresser.sv
// Maps VGA h/v counters to a linear framebuffer read address for an image placed
// at a frame-latched origin and replicated 1x/2x/4x, using counters instead of a multiplier.
module vga_scaled_addresser
    import vga_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_en,
    input  logic [9:0]        h,
    input  logic [9:0]        v,
    input  logic [9:0]        x_origin,
    input  logic [8:0]        y_origin,
    input  logic [1:0]        scale_sel,
    output logic [ADDR_W-1:0] address,
    output logic              blackout,
    output logic              pix_valid
);

    logic [9:0]        x_o;
    logic [8:0]        y_o;
    logic [1:0]        s_m1;
    logic              armed;

    logic              fs;
    logic [10:0]       x;
    logic [10:0]       y;
    logic [10:0]       win_w;
    logic [10:0]       win_h;
    logic              visible;
    logic              col_in;
    logic              row_in;
    logic              line_end;
    logic              shown;
    logic [ADDR_W-1:0] col_idx;
    logic [ADDR_W-1:0] row_base;

    // Coordinates left of/above the active area wrap to large 11-bit values,
    // which can never fall inside a window whose far edge is at most 1663.
    always_comb begin
        fs       = pixel_en && (h == 10'd0) && (v == 10'd0);
        x        = {1'b0, h} - 11'(HBP);
        y        = {1'b0, v} - 11'(VBP);
        case (s_m1)
            2'd1:    begin win_w = 11'(IMG_W * 2); win_h = 11'(IMG_H * 2); end
            2'd3:    begin win_w = 11'(IMG_W * 4); win_h = 11'(IMG_H * 4); end
            default: begin win_w = 11'(IMG_W);     win_h = 11'(IMG_H);     end
        endcase
        visible  = (h >= 10'(HBP)) && (h < 10'(HFP)) && (v >= 10'(VBP)) && (v < 10'(VFP));
        col_in   = (x >= {1'b0, x_o}) && (x < ({1'b0, x_o} + win_w));
        row_in   = (y >= {2'b0, y_o}) && (y < ({2'b0, y_o} + win_h));
        line_end = (h == 10'(HPIXELS - 1));
        shown    = armed && visible && col_in && row_in;
    end

    replicate_counter #(.W(ADDR_W), .STEP(1)) u_col (
        .clk     (clk),
        .reset   (reset),
        .en      (pixel_en),
        .clear   (x == {1'b0, x_o}),
        .advance (col_in && !fs),
        .s_m1    (s_m1),
        .idx     (col_idx)
    );

    // Rows advance at line end rather than window end so horizontal clipping is harmless.
    replicate_counter #(.W(ADDR_W), .STEP(IMG_W)) u_row (
        .clk     (clk),
        .reset   (reset),
        .en      (pixel_en),
        .clear   (fs),
        .advance (!fs && line_end && row_in),
        .s_m1    (s_m1),
        .idx     (row_base)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x_o       <= '0;
            y_o       <= '0;
            s_m1      <= 2'd0;
            armed     <= 1'b0;
            address   <= '0;
            blackout  <= 1'b1;
            pix_valid <= 1'b0;
        end else if (pixel_en) begin
            if (fs) begin
                x_o   <= x_origin;
                y_o   <= y_origin;
                s_m1  <= scale_m1(scale_sel);
                armed <= 1'b1;
            end
            address   <= shown ? (row_base + col_idx) : '0;
            blackout  <= ~shown;
            pix_valid <= shown;
        end
    end

endmodule

// File: tb/tb_vga_scaled_addresser.sv
// Randomized scan bench for vga_scaled_addresser with a closed-form position model
// and a table of hand-computed addresses at fixed screen positions.
module tb_vga_scaled_addresser;

    localparam int IMG_W  = 160;
    localparam int IMG_H  = 120;
    localparam int ADDR_W = 16;
    localparam int NPIN   = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              pixel_en;
    logic [9:0]        h;
    logic [9:0]        v;
    logic [9:0]        x_origin;
    logic [8:0]        y_origin;
    logic [1:0]        scale_sel;
    logic [ADDR_W-1:0] address;
    logic              blackout;
    logic              pix_valid;

    vga_scaled_addresser #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_en  (pixel_en),
        .h         (h),
        .v         (v),
        .x_origin  (x_origin),
        .y_origin  (y_origin),
        .scale_sel (scale_sel),
        .address   (address),
        .blackout  (blackout),
        .pix_valid (pix_valid)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] exp_q[$];
    logic [18:0] pin_q[$];

    int          m_xo, m_yo, m_s;
    bit          m_armed;
    logic [17:0] last_e;
    int          frame_no = -1;
    int          cfg_xo, cfg_yo, cfg_sel;

    // {frame, h, v, address, blackout}
    int pin_tab [0:NPIN-1][0:4] = '{
        '{0, 144, 31,     0, 0}, '{0, 303, 31,   159, 0}, '{0, 304, 31,     0, 1},
        '{0, 144, 32,   160, 0},
        '{1, 144, 31,     0, 0}, '{1, 145, 31,     0, 0}, '{1, 146, 31,     1, 0},
        '{1, 146, 32,     1, 0}, '{1, 144, 33,   160, 0}, '{1, 463, 270, 19199, 0},
        '{2, 244, 81,     0, 0}, '{2, 243, 81,     0, 1},
        '{3, 783, 31,    39, 0}, '{3, 784, 31,     0, 1}, '{3, 744, 32,   160, 0},
        '{5, 144, 31,     0, 0}, '{5, 147, 31,     0, 0}, '{5, 148, 31,     1, 0},
        '{5, 144, 201,    0, 1}
    };

    function automatic int s_of(input int sel);
        return (sel == 1) ? 2 : (sel == 2) ? 4 : 1;
    endfunction

    // Output the screen position must produce: {address, blackout, pix_valid}.
    function automatic logic [17:0] model_pix(input int hh, input int vv);
        int x;
        int y;
        bit shown;
        x = hh - 144;
        y = vv - 31;
        shown = m_armed && hh >= 144 && hh < 784 && vv >= 31 && vv < 511 &&
                x >= m_xo && x < m_xo + IMG_W * m_s && y >= m_yo && y < m_yo + IMG_H * m_s;
        if (!shown) return {16'd0, 1'b1, 1'b0};
        return {16'(((y - m_yo) / m_s) * IMG_W + (x - m_xo) / m_s), 1'b0, 1'b1};
    endfunction

    function automatic logic [18:0] pin_lookup(input int hh, input int vv);
        for (int i = 0; i < NPIN; i++)
            if (pin_tab[i][0] == frame_no && pin_tab[i][1] == hh && pin_tab[i][2] == vv)
                return {1'b1, 1'(pin_tab[i][4]), 16'(pin_tab[i][3])};
        return '0;
    endfunction

    // driver tasks
    task automatic step(input bit pe, input bit rst, input int hh, input int vv);
        logic [17:0] e;
        logic [18:0] p;
        bit fs;
        @(negedge clk);
        fs       = pe && !rst && hh == 0 && vv == 0;
        reset    = rst;
        pixel_en = pe;
        h        = 10'(hh);
        v        = 10'(vv);
        if (pe && hh == 0 && vv == 0) begin
            x_origin  = 10'(cfg_xo);
            y_origin  = 9'(cfg_yo);
            scale_sel = 2'(cfg_sel);
        end else begin
            x_origin  = 10'($urandom);
            y_origin  = 9'($urandom);
            scale_sel = 2'($urandom);
        end
        p = '0;
        if (rst) begin
            m_armed = 1'b0;
            e = {16'd0, 1'b1, 1'b0};
        end else if (pe) begin
            if (fs) begin
                m_xo = cfg_xo;
                m_yo = cfg_yo;
                m_s = s_of(cfg_sel);
                m_armed = 1'b1;
                frame_no++;
            end
            e = model_pix(hh, vv);
            p = pin_lookup(hh, vv);
        end else begin
            e = last_e;
        end
        last_e = e;
        exp_q.push_back(e);
        pin_q.push_back(p);
    endtask

    task automatic pix(input int hh, input int vv);
        if ($urandom_range(0, 4) == 0)
            repeat ($urandom_range(1, 2))
                step(1'b0, 1'b0, int'($urandom_range(0, 799)), int'($urandom_range(0, 520)));
        step(1'b1, 1'b0, hh, vv);
    endtask

    task automatic run_frame(input int xo, input int yo, input int sel, input int rst_line);
        int s, y_end, y, hs, n;
        bit full;
        cfg_xo = xo;
        cfg_yo = yo;
        cfg_sel = sel;
        s = s_of(sel);
        y_end = (yo + IMG_H * s > 480) ? 480 : yo + IMG_H * s;
        pix(0, 0);
        for (int vv = 1; vv < 521; vv++) begin
            if (vv == rst_line)
                step(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 799)), vv);
            y = vv - 31;
            if (vv >= 31 && y >= yo && y < y_end) begin
                full = (y == yo) || (y == y_end - 1);
                hs = 144 + xo;
                if (xo > 0) pix(hs - 1, vv);
                n = full ? IMG_W * s : int'($urandom_range(4, 8));
                if (n > 799 - hs) n = 799 - hs;
                for (int i = 0; i < n; i++) pix(hs + i, vv);
                if (full && hs + n < 799) pix(hs + n, vv);
                pix(799, vv);
            end else if ($urandom_range(0, 3) == 0) begin
                pix(int'($urandom_range(0, 799)), vv);
            end
        end
    endtask

    // scoreboard
    initial begin
        logic [17:0] e;
        logic [18:0] p;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                p = pin_q.pop_front();
                n_cmp++;
                if ({address, blackout, pix_valid} !== e) begin
                    n_bad++;
                    $display("FAIL out t=%0t h=%0d v=%0d: got addr=%0d black=%0b valid=%0b, want addr=%0d black=%0b valid=%0b",
                             $time, h, v, address, blackout, pix_valid, e[17:2], e[1], e[0]);
                end
                if (p[18]) begin
                    n_cmp++;
                    if (address !== p[15:0] || blackout !== p[16]) begin
                        n_bad++;
                        $display("FAIL pin frame=%0d t=%0t: got addr=%0d black=%0b, want addr=%0d black=%0b",
                                 frame_no, $time, address, blackout, p[15:0], p[16]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        pixel_en = 1'b0;
        h = '0;
        v = '0;
        x_origin = '0;
        y_origin = '0;
        scale_sel = '0;
        cfg_xo = 0;
        cfg_yo = 0;
        cfg_sel = 0;
        m_xo = 0;
        m_yo = 0;
        m_s = 1;
        m_armed = 1'b0;
        last_e = {16'd0, 1'b1, 1'b0};
        repeat (3) step(1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) pix(144 + i, 31);
        run_frame(0, 0, 0, -1);
        repeat (3) step(1'b0, 1'b0, int'($urandom_range(0, 799)), int'($urandom_range(0, 520)));
        run_frame(0, 0, 1, -1);
        run_frame(100, 50, 0, -1);
        run_frame(600, 0, 0, -1);
        run_frame(0, 0, 1, -1);
        run_frame(0, 0, 2, 200);
        repeat (3)
            run_frame(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                      int'($urandom_range(0, 3)), -1);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
